// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11/DHT22 single-wire controller.
// Holds the FSM state encoding (also visible on the debug port), the mode
// constants, default timing constants, the frame length and a checksum helper.
package dht_pkg;

    localparam int FRAME_BITS = 40;
    localparam int STATE_W    = 4;

    // State encoding; IDLE is zero so a reset controller reads debug == 0.
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_START_LOW = 4'd1;
    localparam logic [3:0] ST_RELEASE   = 4'd2;
    localparam logic [3:0] ST_RESP_L    = 4'd3;
    localparam logic [3:0] ST_RESP_H    = 4'd4;
    localparam logic [3:0] ST_BIT_L     = 4'd5;
    localparam logic [3:0] ST_BIT_H     = 4'd6;
    localparam logic [3:0] ST_CHECK     = 4'd7;
    localparam logic [3:0] ST_FINISH    = 4'd8;

    localparam logic MODE_DHT11 = 1'b0;
    localparam logic MODE_DHT22 = 1'b1;

    localparam int DEF_CLK_FREQ_HZ       = 100_000_000;
    localparam int DEF_START_LOW_US_DHT11 = 18000;
    localparam int DEF_START_LOW_US_DHT22 = 1100;
    localparam int DEF_BIT_THRESH_US     = 50;
    localparam int DEF_TIMEOUT_US        = 200;
    localparam int DEF_SYNC_STAGES       = 2;

    // Byte 4 must equal the 8-bit wrapped sum of bytes 0..3 (byte 0 is the MSB).
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        logic [7:0] sum;
        sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return sum == f[7:0];
    endfunction

endpackage

// File: rtl/dht_tick_gen.sv
// 1 us timing strobe for the DHT controller.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous, active-high reset
//   tick_1u out one-cycle strobe every CLK_FREQ_HZ/1e6 clocks (every clock if
//               the clock is 1 MHz or slower)
module dht_tick_gen #(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_1u
);

    localparam int DIV = (CLK_FREQ_HZ / 1_000_000 > 1) ? CLK_FREQ_HZ / 1_000_000 : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            tick_1u <= 1'b0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            tick_1u <= 1'b1;
        end else begin
            cnt     <= cnt + 1'b1;
            tick_1u <= 1'b0;
        end
    end

endmodule

// File: rtl/dht_sensor_ctrl.sv
// Single-wire controller for DHT11/DHT22 sensors.
// Issues the host start-low pulse, decodes the 40-bit frame from high-pulse
// widths on the synchronised line, validates the checksum and times out any
// sensor-driven phase that stalls. Readings are held until the next good frame.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   start, mode   request (accepted only in IDLE) and sensor type latched with it
//   busy          high from the accepted start until the done cycle
//   dht_done      one-cycle pulse ending every transaction, good or failed
//   dht_valid     held data is from the latest transaction and passed
//   checksum_err  last transaction failed the checksum
//   timeout_err   last transaction timed out
//   humidity      {byte0, byte1} of the last good frame
//   temperature   {byte2, byte3} of the last good frame (sign bit passed through)
//   debug         current state encoding
//   dhtio         open-drain sensor line (driven 0 or Z only)
// Request handshake: start is a level/pulse sampled only while IDLE; a start
// seen in any other state (including the FINISH cycle) is dropped, there is no
// queueing and no acknowledge other than busy rising on the next clock.
module dht_sensor_ctrl
    import dht_pkg::*;
#(
    parameter int CLK_FREQ_HZ        = DEF_CLK_FREQ_HZ,
    parameter int START_LOW_US_DHT11 = DEF_START_LOW_US_DHT11,
    parameter int START_LOW_US_DHT22 = DEF_START_LOW_US_DHT22,
    parameter int BIT_THRESH_US      = DEF_BIT_THRESH_US,
    parameter int TIMEOUT_US         = DEF_TIMEOUT_US,
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    output logic        busy,
    output logic        dht_done,
    output logic        dht_valid,
    output logic        checksum_err,
    output logic        timeout_err,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic [3:0]  debug,
    inout  wire         dhtio
);

    // The us counter must reach the longest start-low time; one spare bit
    // keeps saturation well clear of every compare value.
    localparam int LOW_MAX = (START_LOW_US_DHT11 > START_LOW_US_DHT22) ?
                             START_LOW_US_DHT11 : START_LOW_US_DHT22;
    localparam int US_NEED = (LOW_MAX > TIMEOUT_US) ? LOW_MAX : TIMEOUT_US;
    localparam int US_W    = $clog2(US_NEED + 1) + 1;

    localparam logic [US_W-1:0] US_SAT  = '1;
    localparam logic [US_W-1:0] LOW11   = US_W'(START_LOW_US_DHT11);
    localparam logic [US_W-1:0] LOW22   = US_W'(START_LOW_US_DHT22);
    localparam logic [US_W-1:0] THRESH  = US_W'(BIT_THRESH_US);
    localparam logic [US_W-1:0] TO_LIM  = US_W'(TIMEOUT_US);
    localparam logic [5:0]      LAST_BIT = 6'(FRAME_BITS - 1);

    logic [3:0]             state, state_nxt;
    logic [US_W-1:0]        us_cnt;
    logic [5:0]             bit_cnt;
    logic [FRAME_BITS-1:0]  frame;
    logic                   mode_q;
    logic                   tick_1u;
    logic [SYNC_STAGES-1:0] sync;
    logic                   line_prev;
    logic                   line, rise, fall;
    logic                   wait_phase, to_hit;
    logic [US_W-1:0]        low_target;

    dht_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .tick_1u (tick_1u)
    );

    // Synchroniser resets to 1 (idle pulled-up line) so leaving reset never
    // fakes a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= '1;
            line_prev <= 1'b1;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], dhtio};
            line_prev <= sync[SYNC_STAGES-1];
        end
    end

    assign line = sync[SYNC_STAGES-1];
    assign rise = line & ~line_prev;
    assign fall = ~line & line_prev;

    assign low_target = (mode_q == MODE_DHT22) ? LOW22 : LOW11;
    assign wait_phase = (state inside {ST_RELEASE, ST_RESP_L, ST_RESP_H, ST_BIT_L, ST_BIT_H});
    assign to_hit     = wait_phase && (us_cnt >= TO_LIM);

    always_comb begin
        state_nxt = state;
        if (to_hit) begin
            state_nxt = ST_FINISH;
        end else begin
            case (state)
                ST_IDLE:      if (start) state_nxt = ST_START_LOW;
                ST_START_LOW: if (us_cnt >= low_target) state_nxt = ST_RELEASE;
                ST_RELEASE:   if (fall) state_nxt = ST_RESP_L;
                ST_RESP_L:    if (rise) state_nxt = ST_RESP_H;
                ST_RESP_H:    if (fall) state_nxt = ST_BIT_L;
                ST_BIT_L:     if (rise) state_nxt = ST_BIT_H;
                ST_BIT_H:     if (fall) state_nxt = (bit_cnt == LAST_BIT) ? ST_CHECK : ST_BIT_L;
                ST_CHECK:     state_nxt = ST_FINISH;
                ST_FINISH:    state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            us_cnt       <= '0;
            bit_cnt      <= '0;
            frame        <= '0;
            mode_q       <= MODE_DHT11;
            dht_valid    <= 1'b0;
            checksum_err <= 1'b0;
            timeout_err  <= 1'b0;
            humidity     <= '0;
            temperature  <= '0;
        end else begin
            state <= state_nxt;

            // Every state entry restarts the measurement window.
            if (state_nxt != state)
                us_cnt <= '0;
            else if (tick_1u && us_cnt != US_SAT)
                us_cnt <= us_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q       <= mode;
                        checksum_err <= 1'b0;
                        timeout_err  <= 1'b0;
                    end
                end
                ST_RESP_H: bit_cnt <= '0;
                ST_BIT_H: begin
                    // High width decides the bit; MSB of byte 0 arrives first.
                    if (!to_hit && fall) begin
                        frame <= {frame[FRAME_BITS-2:0], (us_cnt >= THRESH)};
                        if (bit_cnt != LAST_BIT)
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (frame_ok(frame)) begin
                        humidity    <= frame[39:24];
                        temperature <= frame[23:8];
                        dht_valid   <= 1'b1;
                    end else begin
                        checksum_err <= 1'b1;
                        dht_valid    <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (to_hit) begin
                timeout_err <= 1'b1;
                dht_valid   <= 1'b0;
            end
        end
    end

    // Open drain: only ever pull low; the external resistor provides the high.
    assign dhtio    = (state == ST_START_LOW) ? 1'b0 : 1'bz;
    assign busy     = (state != ST_IDLE) && (state != ST_FINISH);
    assign dht_done = (state == ST_FINISH);
    assign debug    = state;

endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// Bench for dht_sensor_ctrl: 2 MHz clock so one us is two clocks, a sensor
// model on the open-drain line, and a reference model of the held outputs.
module tb_dht_sensor_ctrl;

    localparam int CLK_HZ = 2_000_000;
    localparam int CPU    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        busy, dht_done, dht_valid, checksum_err, timeout_err;
    logic [15:0] humidity, temperature;
    logic [3:0]  debug;
    wire         dhtio;
    logic        sens_low = 1'b0;

    pullup (dhtio);
    assign dhtio = sens_low ? 1'b0 : 1'bz;

    dht_sensor_ctrl #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .busy         (busy),
        .dht_done     (dht_done),
        .dht_valid    (dht_valid),
        .checksum_err (checksum_err),
        .timeout_err  (timeout_err),
        .humidity     (humidity),
        .temperature  (temperature),
        .debug        (debug),
        .dhtio        (dhtio)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: committed results and the result expected from the
    // transaction in flight.
    logic [15:0] m_hum = '0, m_temp = '0;
    logic        m_valid = 1'b0, m_cks = 1'b0, m_to = 1'b0;
    logic [15:0] p_hum = '0, p_temp = '0;
    logic        p_valid = 1'b0, p_cks = 1'b0, p_to = 1'b0;
    bit          txn_open = 1'b0;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic us(input int n);
        cyc(n * CPU);
    endtask

    task automatic model_clear();
        m_hum = '0; m_temp = '0; m_valid = 1'b0; m_cks = 1'b0; m_to = 1'b0;
        txn_open = 1'b0;
    endtask

    // Per-cycle compare of the held outputs whenever the controller is idle.
    always @(negedge clk) begin
        if (chk_en) begin
            if (dht_done) begin
                check("done_expected", {31'b0, txn_open}, 32'd1);
                m_hum = p_hum; m_temp = p_temp;
                m_valid = p_valid; m_cks = p_cks; m_to = p_to;
                txn_open = 1'b0;
            end
            if (!busy) begin
                check("humidity", humidity, m_hum);
                check("temperature", temperature, m_temp);
                check("dht_valid", dht_valid, m_valid);
                check("checksum_err", checksum_err, m_cks);
                check("timeout_err", timeout_err, m_to);
                if (!sens_low) check("line_released", dhtio, 1);
            end
        end
    end

    // One full transaction: start request, start-low measurement, then the
    // sensor side. abort_bit resets the DUT during that bit's high phase;
    // poke_bit pulses start during that bit's low phase.
    task automatic run_txn(input logic m, input logic [39:0] f, input bit silent,
                           input int abort_bit, input int poke_bit);
        int low_cyc, rel_cyc, exp_low, wait_cyc;
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        p_hum = m_hum; p_temp = m_temp; p_valid = 1'b0; p_cks = 1'b0; p_to = 1'b0;
        if (silent) p_to = 1'b1;
        else if (s == f[7:0]) begin
            p_hum = f[39:24]; p_temp = f[23:8]; p_valid = 1'b1;
        end else p_cks = 1'b1;

        start = 1'b1; mode = m;
        cyc(1);
        start = 1'b0;
        txn_open = 1'b1;
        check("busy_after_start", busy, 1);

        low_cyc = 0;
        while (dhtio === 1'b0 && low_cyc < 40000) begin
            cyc(1);
            low_cyc++;
        end
        exp_low = CPU * (m ? 1100 : 18000);
        check_range(m ? "start_low_dht22" : "start_low_dht11", low_cyc, exp_low - CPU, exp_low + CPU);

        if (silent) begin
            rel_cyc = 0;
            while (!dht_done && rel_cyc < 1000) begin
                cyc(1);
                rel_cyc++;
            end
            check_range("timeout_latency", rel_cyc, 198 * CPU, 203 * CPU);
            return;
        end

        us(20);
        sens_low = 1'b1; us(80);
        sens_low = 1'b0; us(80);
        for (int i = 0; i < 40; i++) begin
            sens_low = 1'b1;
            if (i == poke_bit) begin
                start = 1'b1; mode = 1'b0;
                cyc(1);
                start = 1'b0;
                cyc(20 * CPU - 1);
            end else begin
                us(20);
            end
            sens_low = 1'b0;
            if (i == abort_bit) begin
                us(10);
                model_clear();
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
                check("rst_busy", busy, 0);
                check("rst_done", dht_done, 0);
                check("rst_valid", dht_valid, 0);
                check("rst_hum", humidity, 0);
                check("rst_temp", temperature, 0);
                check("rst_cks", checksum_err, 0);
                check("rst_to", timeout_err, 0);
                check("rst_debug", debug, 0);
                check("rst_line", dhtio, 1);
                return;
            end
            us(f[39 - i] ? 70 : 26);
        end
        sens_low = 1'b1;
        wait_cyc = 0;
        while (!dht_done && wait_cyc < 40) begin
            cyc(1);
            wait_cyc++;
        end
        check("done_seen", dht_done, 1);
    endtask

    task automatic tail();
        us(50);
        sens_low = 1'b0;
        us(20);
    endtask

    initial begin
        cyc(5);
        check("reset_busy", busy, 0);
        check("reset_done", dht_done, 0);
        check("reset_valid", dht_valid, 0);
        check("reset_hum", humidity, 0);
        check("reset_temp", temperature, 0);
        check("reset_errs", {checksum_err, timeout_err}, 0);
        check("reset_debug", debug, 0);
        check("reset_line", dhtio, 1);
        rst = 1'b0;
        cyc(2);
        chk_en = 1'b1;

        // DHT11 good frame.
        run_txn(1'b0, 40'h37_00_18_05_54, 1'b0, -1, -1);
        tail();
        check("t1_hum", humidity, 16'h3700);
        check("t1_temp", temperature, 16'h1805);
        check("t1_valid", dht_valid, 1);
        check("t1_errs", {checksum_err, timeout_err}, 0);

        // Bad checksum keeps the previous reading.
        run_txn(1'b1, 40'h37_00_18_05_55, 1'b0, -1, -1);
        tail();
        check("t3_cks", checksum_err, 1);
        check("t3_valid", dht_valid, 0);
        check("t3_hum", humidity, 16'h3700);

        // Silent sensor.
        run_txn(1'b1, 40'h0, 1'b1, -1, -1);
        tail();
        check("t4_to", timeout_err, 1);
        check("t4_busy", busy, 0);
        check("t4_cks", checksum_err, 0);
        check("t4_hum", humidity, 16'h3700);

        // DHT22 negative temperature, with a start pulse while busy, then a
        // start arriving exactly in the done cycle.
        run_txn(1'b1, 40'h02_8C_80_65_73, 1'b0, -1, 12);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        check("finish_start_ignored", busy, 0);
        tail();
        check("t5_hum", humidity, 16'h028C);
        check("t5_temp", temperature, 16'h8065);
        check("t5_valid", dht_valid, 1);
        check("t5_errs", {checksum_err, timeout_err}, 0);

        // Reset during bit 20.
        run_txn(1'b1, 40'h37_00_18_05_54, 1'b0, 20, -1);
        us(300);
        check("t6_idle", busy, 0);
        check("t6_hum", humidity, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run did not complete within cycle budget");
        $fatal(1);
    end

endmodule
